// File: rtl/msinc_arbiter_pkg.sv
// Shared constants and types for the unified program/data memory arbiter.
package msinc_arb_pkg;
   localparam int MEM_AW = 12;
   localparam int MEM_DW = 32;
   localparam int P_IF   = 0;
   localparam int P_LSU  = 1;

   typedef logic [MEM_AW-1:0] mem_addr_t;
endpackage

// File: rtl/msinc_arbiter_if.sv
// Bundles the two requester ports and the memory pins seen by msinc_arbiter.
interface msinc_arbiter_if
   import msinc_arb_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
);
   logic [1:0]      req_i;
   logic [1:0]      we_i;
   logic [2*AW-1:0] addr_i;
   logic [2*DW-1:0] wdata_i;
   logic [1:0]      gnt_o;
   logic [1:0]      rvalid_o;
   logic [2*DW-1:0] rdata_o;
   logic            mem_we_o;
   logic [AW-1:0]   mem_addr_w_o;
   logic [DW-1:0]   mem_wdata_o;
   logic [AW-1:0]   mem_addr_r_o;
   logic [DW-1:0]   mem_rdata_i;

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
      output gnt_o, rvalid_o, rdata_o, mem_we_o, mem_addr_w_o, mem_wdata_o, mem_addr_r_o
   );

   modport master (
      output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, mem_we_o, mem_addr_w_o, mem_wdata_o, mem_addr_r_o
   );
endinterface

// File: rtl/msinc_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the priority flop hands the next conflict to the loser.
module rr_arb2
   import msinc_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic r_prio;
   logic w_conflict;

   assign w_conflict = &req;

   always_comb begin
      gnt = req;
      if (w_conflict) begin
         gnt = r_prio ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prio <= 1'b0;
      end else if (w_conflict) begin
         r_prio <= ~r_prio;
      end
   end
endmodule

// File: rtl/msinc_arbiter.sv
// Shares one async-read/sync-write memory between fetch (port 0) and LSU (port 1),
// with independent read/write round-robin and a registered, write-forwarded read response.
module msinc_arbiter
   import msinc_arb_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
)(
   input  logic           clk_i,
   input  logic           rst_ni,
   msinc_arbiter_if.slave bus
);
   logic [1:0]    w_rd_req;
   logic [1:0]    w_wr_req;
   logic [1:0]    w_rd_gnt;
   logic [1:0]    w_wr_gnt;
   logic [AW-1:0] w_addr  [2];
   logic [DW-1:0] w_wdata [2];
   logic [AW-1:0] w_addr_r;
   logic [AW-1:0] w_addr_w;
   logic [DW-1:0] w_wdata_w;
   logic          w_fwd;
   logic [DW-1:0] w_cap;
   logic [1:0]    r_rvalid;
   logic [DW-1:0] r_rdata [2];

   assign w_addr[P_IF]   = bus.addr_i[P_IF*AW +: AW];
   assign w_addr[P_LSU]  = bus.addr_i[P_LSU*AW +: AW];
   assign w_wdata[P_IF]  = bus.wdata_i[P_IF*DW +: DW];
   assign w_wdata[P_LSU] = bus.wdata_i[P_LSU*DW +: DW];

   assign w_rd_req = bus.req_i & ~bus.we_i;
   assign w_wr_req = bus.req_i &  bus.we_i;

   rr_arb2 u_rd_arb (.clk_i(clk_i), .rst_ni(rst_ni), .req(w_rd_req), .gnt(w_rd_gnt));
   rr_arb2 u_wr_arb (.clk_i(clk_i), .rst_ni(rst_ni), .req(w_wr_req), .gnt(w_wr_gnt));

   // With no grant the muxes fall through to port 0, which the memory ignores.
   assign w_addr_r  = w_rd_gnt[P_LSU] ? w_addr[P_LSU]  : w_addr[P_IF];
   assign w_addr_w  = w_wr_gnt[P_LSU] ? w_addr[P_LSU]  : w_addr[P_IF];
   assign w_wdata_w = w_wr_gnt[P_LSU] ? w_wdata[P_LSU] : w_wdata[P_IF];

   // The memory only sees the write after this edge, so a same-address read takes the write data.
   assign w_fwd = (|w_rd_gnt) && (|w_wr_gnt) && (w_addr_r == w_addr_w);
   assign w_cap = w_fwd ? w_wdata_w : bus.mem_rdata_i;

   assign bus.gnt_o        = w_rd_gnt | w_wr_gnt;
   assign bus.mem_we_o     = rst_ni & (|w_wr_gnt);
   assign bus.mem_addr_w_o = w_addr_w;
   assign bus.mem_wdata_o  = w_wdata_w;
   assign bus.mem_addr_r_o = w_addr_r;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid   <= 2'b00;
         r_rdata[0] <= '0;
         r_rdata[1] <= '0;
      end else begin
         r_rvalid <= w_rd_gnt;
         for (int n = 0; n < 2; n++) begin
            if (w_rd_gnt[n]) begin
               r_rdata[n] <= w_cap;
            end
         end
      end
   end

   assign bus.rvalid_o = r_rvalid;
   assign bus.rdata_o  = {r_rdata[P_LSU], r_rdata[P_IF]};
endmodule

// File: tb/tb_msinc_arbiter.sv
// Directed bench for msinc_arbiter: behavioural memory, read-response scoreboard, assertion checks.
module tb_msinc_arbiter;
   import msinc_arb_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   msinc_arbiter_if bus ();
   msinc_arbiter dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   logic [31:0] mem [4096];
   bit          mem_ready = 1'b0;

   function automatic logic [31:0] seed(int a);
      return 32'hA5C3_0000 | 32'(a);
   endfunction

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 4096; i++) mem[i] <= seed(i);
         mem_ready <= 1'b1;
      end else if (bus.mem_we_o) begin
         mem[bus.mem_addr_w_o] <= bus.mem_wdata_o;
      end
   end
   assign bus.mem_rdata_i = mem[bus.mem_addr_r_o];

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [1:0]  exp_rv = 2'b00;
   logic [31:0] exp_last [2] = '{32'h0, 32'h0};

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(logic [1:0] req, logic [1:0] we, mem_addr_t a0, mem_addr_t a1,
                        logic [31:0] d0, logic [31:0] d1);
      bus.req_i   = req;
      bus.we_i    = we;
      bus.addr_i  = {a1, a0};
      bus.wdata_i = {d1, d0};
   endtask

   task automatic edge_check(string tag);
      exp_t e;
      @(posedge clk);
      #1;
      chk({tag, ".rvalid"}, 64'(bus.rvalid_o), 64'(exp_rv));
      for (int n = 0; n < 2; n++) begin
         if (bus.rvalid_o[n]) begin
            chk({tag, ".sb_avail"}, 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk({tag, ".port"}, 64'(e.port), 64'(n));
               exp_last[n] = e.data;
            end
         end
      end
      chk({tag, ".rdata0"}, 64'(bus.rdata_o[31:0]),  64'(exp_last[0]));
      chk({tag, ".rdata1"}, 64'(bus.rdata_o[63:32]), 64'(exp_last[1]));
      exp_rv = 2'b00;
   endtask

   task automatic step(string tag, logic [1:0] req, logic [1:0] we, mem_addr_t a0, mem_addr_t a1,
                       logic [31:0] d0, logic [31:0] d1, logic [1:0] exp_gnt,
                       logic [31:0] x0, logic [31:0] x1);
      drive(req, we, a0, a1, d0, d1);
      #1;
      chk({tag, ".gnt"},    64'(bus.gnt_o),    64'(exp_gnt));
      chk({tag, ".mem_we"}, 64'(bus.mem_we_o), 64'(|(exp_gnt & we)));
      exp_rv = exp_gnt & req & ~we;
      if (exp_rv[0]) sb.push_back('{0, x0});
      if (exp_rv[1]) sb.push_back('{1, x1});
      edge_check(tag);
   endtask

   initial begin
      drive(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0);

      // Reset held: requests toggle, nothing may respond or write.
      for (int i = 0; i < 3; i++) begin
         drive((i % 2 == 1) ? 2'b11 : 2'b01, (i == 1) ? 2'b00 : 2'b11,
               12'h005, 12'h006, 32'h1111_1111, 32'h2222_2222);
         #1;
         chk("rst.mem_we", 64'(bus.mem_we_o), 64'd0);
         edge_check("rst");
      end
      rst_n = 1'b1;

      step("rd0",    2'b01, 2'b00, 12'h000, 12'h000, 0, 0, 2'b01, seed(12'h000), 0);

      step("rdc1",   2'b11, 2'b00, 12'h010, 12'h020, 0, 0, 2'b01, seed(12'h010), seed(12'h020));
      step("rdc2",   2'b11, 2'b00, 12'h010, 12'h020, 0, 0, 2'b10, seed(12'h010), seed(12'h020));
      step("rdc3",   2'b11, 2'b00, 12'h010, 12'h020, 0, 0, 2'b01, seed(12'h010), seed(12'h020));
      step("rdc4",   2'b11, 2'b00, 12'h010, 12'h020, 0, 0, 2'b10, seed(12'h010), seed(12'h020));

      step("par",    2'b11, 2'b10, 12'h004, 12'h100, 0, 32'hDEAD_BEEF, 2'b11, seed(12'h004), 0);
      step("rd100",  2'b01, 2'b00, 12'h100, 12'h000, 0, 0, 2'b01, 32'hDEAD_BEEF, 0);

      step("fwd",    2'b11, 2'b10, 12'h0AB, 12'h0AB, 0, 32'h1234_5678, 2'b11, 32'h1234_5678, 0);
      step("rd0ab",  2'b01, 2'b00, 12'h0AB, 12'h000, 0, 0, 2'b01, 32'h1234_5678, 0);
      step("fwdrev", 2'b11, 2'b01, 12'h0C0, 12'h0C0, 32'hCAFE_F00D, 0, 2'b11, 0, 32'hCAFE_F00D);

      step("wrc1",   2'b11, 2'b11, 12'h200, 12'h200, 32'h1, 32'h2, 2'b01, 0, 0);
      step("wrc1h",  2'b10, 2'b10, 12'h200, 12'h200, 32'h1, 32'h2, 2'b10, 0, 0);
      step("rd200",  2'b01, 2'b00, 12'h200, 12'h000, 0, 0, 2'b01, 32'h2, 0);
      step("wrc2",   2'b11, 2'b11, 12'h201, 12'h201, 32'h3, 32'h4, 2'b10, 0, 0);
      step("wrc2h",  2'b01, 2'b01, 12'h201, 12'h201, 32'h3, 32'h4, 2'b01, 0, 0);
      step("rd201",  2'b01, 2'b00, 12'h201, 12'h000, 0, 0, 2'b01, 32'h3, 0);

      // Leave both pointers at 1 so the reset below has something to clear.
      step("wrc3",   2'b11, 2'b11, 12'h300, 12'h300, 32'h6, 32'h5, 2'b01, 0, 0);
      step("wrc3h",  2'b11, 2'b10, 12'h010, 12'h300, 0, 32'h5, 2'b11, seed(12'h010), 0);
      step("rdc5",   2'b11, 2'b00, 12'h010, 12'h020, 0, 0, 2'b01, seed(12'h010), 0);

      drive(2'b10, 2'b00, 12'h010, 12'h020, 0, 0);
      #1;
      chk("rstmid.gnt", 64'(bus.gnt_o), 64'(2'b10));
      #2;
      rst_n = 1'b0;
      exp_rv = 2'b00;
      exp_last = '{32'h0, 32'h0};
      edge_check("rstmid");
      rst_n = 1'b1;

      step("post_rd",  2'b11, 2'b00, 12'h010, 12'h020, 0, 0, 2'b01, seed(12'h010), 0);
      step("post_rdh", 2'b10, 2'b00, 12'h010, 12'h020, 0, 0, 2'b10, 0, seed(12'h020));
      step("post_wr",  2'b11, 2'b11, 12'h300, 12'h300, 32'h7, 32'h8, 2'b01, 0, 0);
      step("post_wrh", 2'b10, 2'b10, 12'h300, 12'h300, 32'h7, 32'h8, 2'b10, 0, 0);
      step("rd300",    2'b01, 2'b00, 12'h300, 12'h000, 0, 0, 2'b01, 32'h8, 0);
      step("idle",     2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 0, 0);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("mem200", 64'(mem[12'h200]), 64'h2);
      chk("mem300", 64'(mem[12'h300]), 64'h8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/msinc_arbiter.md
# msinc_arbiter

Two-requester arbiter sharing the unified 4096×32 program/data memory between the instruction-fetch unit (port 0) and the load/store unit (port 1). The memory has one asynchronous read port and one synchronous write port. The arbiter grants each memory port independently with round-robin fairness. It registers read data into a one-cycle response with same-cycle write-to-read forwarding. It sits between the core's fetch/LSU request interfaces and the memory's `WE/AddrR/AddrW/DataW/DataR` pins.

## Interface
- `AW`, default 12: word-address width; memory depth is 2**AW.
- `DW`, default 32: data word width.
- `clk_i` in 1: clock. All state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 2: per-port request; bit n is port n.
- `we_i` in 2: per-port write enable, qualified by `req_i`. 1 = write, 0 = read.
- `addr_i` in 2×AW: per-port word address. Port n uses bits [n*AW +: AW].
- `wdata_i` in 2×DW: per-port write data.
- `gnt_o` out 2: per-port grant, combinational, same cycle as the request.
- `rvalid_o` out 2: per-port read response valid, one cycle after a granted read.
- `rdata_o` out 2×DW: per-port registered read data.
- `mem_we_o` out 1: write enable to the memory.
- `mem_addr_w_o` out AW: write address to the memory.
- `mem_wdata_o` out DW: write data to the memory.
- `mem_addr_r_o` out AW: read address to the memory.
- `mem_rdata_i` in DW: asynchronous read data from the memory.

## Operation
- **Request classes.** A port with `req_i[n]=1` requests the write port if `we_i[n]=1`, otherwise the read port.
- **Read and write arbitration.** The read port and the write port are arbitrated independently.
  - A read by one port and a write by the other are both granted in the same cycle.
- **Conflict.** A conflict exists when both ports request the same memory port.
  - The winner is the port indicated by that resource's round-robin pointer (`rd_prio`, `wr_prio`, 1 bit each).
  - On the next edge, the pointer moves to the loser.
  - If there is no conflict, the pointer is unchanged.
- **Ungranted requests.** A requester with `gnt_o[n]=0` holds `req_i`, `we_i`, `addr_i` and `wdata_i` stable until it is granted. The arbiter does not check this; violation is undefined.
- **Write.** When a write is granted:
  - `mem_we_o=1`, `mem_addr_w_o` = winner's address, `mem_wdata_o` = winner's data.
  - The write commits at that edge.
- **Read.** When a read is granted:
  - `mem_addr_r_o` = winner's address.
  - At the edge, the arbiter captures `mem_rdata_i` into `rdata_o[winner]` and sets `rvalid_o[winner]=1` for exactly one cycle.
- **Forwarding.** If a write and a read are granted in the same cycle to the same address, the captured data is the write data, not the stale `mem_rdata_i`.
- **Data hold.** `rdata_o[n]` holds its last value while `rvalid_o[n]=0`.
- **Idle values.**
  - `mem_we_o=0` whenever no write is granted.
  - `mem_addr_r_o`/`mem_addr_w_o` default to port 0's address when idle (don't-care to the memory).
- **Reset** (asynchronous assert, synchronous-to-`clk_i` effect on release):
  - `rvalid_o=2'b00`, `rdata_o=0`, `rd_prio=0`, `wr_prio=0`.
  - `gnt_o` and `mem_*` are combinational. They evaluate from inputs and pointer state during reset, except that `mem_we_o` is forced 0 while `rst_ni=0`.
  - A read granted in the cycle reset asserts produces no `rvalid_o`.
  - Memory contents are not reset.

## Timing
- Grant latency 0: `gnt_o` is combinational from `req_i`, `we_i` and the pointers.
- Write commit at the edge ending the grant cycle. A read of that address granted in the following cycle returns the new data.
- Read response latency 1: `rvalid_o`/`rdata_o` are valid in the cycle after `gnt_o`.
- Throughput: one read plus one write per cycle overall.
- A port re-requesting every cycle is guaranteed a grant within 2 cycles under continuous contention.
- Back-to-back reads by one port, uncontested, give `rvalid_o` every cycle.
- No combinational path from `mem_rdata_i` to any output except through the `rdata_o` register.

## Structure
- Shared package `msinc_arb_pkg`:
  - `MEM_AW=12`, `MEM_DW=32`.
  - Port indices `P_IF=0`, `P_LSU=1`.
  - Typedef `mem_addr_t`.
- Sub-module `rr_arb2`: two-way round-robin arbiter with inputs `clk_i`, `rst_ni`, `req[1:0]` and output `gnt[1:0]`. It owns one priority flop.
  - Instantiated twice, once for the read port and once for the write port, with requests masked by `we_i`.
- The top holds the forwarding compare, the response registers and the memory-pin muxing.

## Test plan
- **Reset.** Hold `rst_ni=0`, toggle reqs -> `rvalid_o=00`, `rdata_o=0`, `mem_we_o=0`. Release, port 0 reads addr 0x000 -> `gnt_o=01`, next cycle `rvalid_o=01` with `rdata_o[0]` = mem[0].
- **Read contention.** Both ports read every cycle, P0 addr 0x010, P1 addr 0x020, for 4 cycles -> grants alternate 01,10,01,10; each `rvalid_o` follows its grant by 1 cycle with the correct word.
- **Parallel read/write.** P1 writes 0xDEADBEEF to 0x100 while P0 reads 0x004 -> `gnt_o=11`, `mem_we_o=1`. Next cycle P0's `rvalid_o` carries mem[0x004]. P0 then reads 0x100 -> 0xDEADBEEF.
- **Forwarding.** P1 writes 0x12345678 to 0x0AB while P0 reads 0x0AB in the same cycle -> `rdata_o[0]=0x12345678` next cycle.
- **Write contention.** Both ports write 0x200, P0 0x1, P1 0x2, held until granted -> P0 granted first (`wr_prio=0` after reset), then P1. Final mem[0x200]=0x2.
- **Reset mid-read.** Assert `rst_ni=0` in the grant cycle of a P1 read -> no `rvalid_o[1]` pulse, both pointers return to 0.
